rle_decoder: RTL and testbench

//   Sequential run-length decoder; inverse of the 64-coefficient RLE encoder in the FULL_JPEG path.

---
 rtl/rle_decoder.sv | 158 +++++++++++++++
 tb/tb_rle_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rle_decoder.sv
// rtl/rle_decoder.sv - sequential 64-coefficient run-length decoder
//
// Takes one packed block of N_COEF symbol slots, each {run, level}, and replays
// N_COEF signed coefficients in index order on a valid/ready stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   encoded block present on in_data
//   in_ready   decoder idle, block accepted when in_valid is also high
//   in_data    N_COEF symbols, slot 0 in the top SYM_W bits
//   out_valid  out_data/out_idx/out_last valid
//   out_ready  downstream accepts the current coefficient
//   out_data   decoded coefficient (two's complement)
//   out_idx    coefficient index 0..N_COEF-1
//   out_last   high with the final index
//   err        sticky per block: run overflow or slots exhausted early
module rle_decoder #(
    parameter int N_COEF = 64,
    parameter int COEF_W = 8,
    parameter int RUN_W  = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_COEF*(RUN_W+COEF_W)-1:0]   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COEF_W-1:0]                  out_data,
    output logic [$clog2(N_COEF)-1:0]          out_idx,
    output logic                               out_last,
    output logic                               err
);
    localparam int SYM_W = RUN_W + COEF_W;
    localparam int BLK_W = N_COEF * SYM_W;
    localparam int IDX_W = $clog2(N_COEF) + 1;
    localparam logic [SYM_W-1:0] EOB      = {SYM_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

    typedef enum logic [2:0] {IDLE, LOAD_SYM, ZERO, LEVEL, FILL} state_t;

    state_t             state, state_next, eff;
    logic [BLK_W-1:0]   sreg;
    logic [IDX_W-1:0]   ptr;        // symbol slots consumed
    logic [IDX_W-1:0]   nidx;       // index of the next coefficient to produce
    logic [RUN_W-1:0]   run_cnt, run_cnt_next, zcnt;
    logic [SYM_W-1:0]   sym;
    logic [RUN_W-1:0]   sym_run;
    logic [COEF_W-1:0]  sym_level, emit_data;
    logic               can_go, fire, emit, shift, err_set, ovf;

    assign in_ready  = (state == IDLE);
    assign sym       = sreg[BLK_W-1 -: SYM_W];
    assign sym_run   = sym[SYM_W-1 -: RUN_W];
    assign sym_level = sym[COEF_W-1:0];
    assign fire      = out_valid && out_ready;
    // Produce a new beat only when the output register is empty or draining.
    assign can_go    = (state != IDLE) && (!out_valid || out_ready) && (nidx <= LAST_IDX);

    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        eff          = state;
        zcnt         = '0;
        emit         = 1'b0;
        emit_data    = '0;
        shift        = 1'b0;
        err_set      = 1'b0;
        ovf          = 1'b0;

        // Symbol decode is folded into the emitting cycle, so LOAD_SYM never
        // costs a bubble: it just selects which emitting behaviour applies.
        if (state == LOAD_SYM) begin
            if (sym == EOB) begin
                eff = FILL;
            end else if ((nidx + IDX_W'(sym_run)) > LAST_IDX) begin
                eff = FILL;
                ovf = 1'b1;
            end else if (sym_run != '0) begin
                eff = ZERO;
            end else begin
                eff = LEVEL;
            end
        end

        if (state == IDLE) begin
            if (in_valid) state_next = LOAD_SYM;
        end else if (can_go) begin
            emit = 1'b1;
            case (eff)
                ZERO: begin
                    zcnt         = ((state == LOAD_SYM) ? sym_run : run_cnt) - RUN_W'(1);
                    run_cnt_next = zcnt;
                    state_next   = (zcnt == '0) ? LEVEL : ZERO;
                end
                LEVEL: begin
                    emit_data = sym_level;
                    shift     = 1'b1;
                    if (nidx == LAST_IDX) begin
                        state_next = FILL;
                    end else if (ptr == LAST_IDX) begin
                        // Every slot used but block not complete.
                        err_set    = 1'b1;
                        state_next = FILL;
                    end else begin
                        state_next = LOAD_SYM;
                    end
                end
                default: begin
                    err_set    = ovf;
                    state_next = FILL;
                end
            endcase
        end

        if (fire && out_last) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            ptr       <= '0;
            nidx      <= '0;
            run_cnt   <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
            if (in_valid && in_ready) begin
                sreg <= in_data;
                ptr  <= '0;
                nidx <= '0;
                err  <= 1'b0;
            end else begin
                if (shift) begin
                    sreg <= sreg << SYM_W;
                    ptr  <= ptr + IDX_W'(1);
                end
                if (emit)    nidx <= nidx + IDX_W'(1);
                if (err_set) err  <= 1'b1;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= emit_data;
                out_idx   <= nidx[IDX_W-2:0];
                out_last  <= (nidx == LAST_IDX);
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rle_decoder.sv
// tb/tb_rle_decoder.sv - directed self-checking bench for rle_decoder
module tb_rle_decoder;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [895:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [5:0]   out_idx;
    logic         out_last;
    logic         err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]   exp_q [64];
    logic [895:0] blk;

    rle_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic put_sym(input int k, input logic [13:0] s);
        blk[895-14*k -: 14] = s;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_q[i] = 8'h00;
    endtask

    // mode 0: always ready; mode 1: alternating ready plus a 3-cycle hold at idx 3
    task automatic run_block(input string name, input int mode, input logic exp_err, input int abort_at);
        int beats, cyc, hold;
        logic       pstall;
        logic [7:0] pd;
        logic [5:0] pi;
        logic       pl;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_data  = blk;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, " in_ready_busy"}, 32'(in_ready), 32'd0);
        check({name, " latency"}, 32'(out_valid), 32'd0);
        beats = 0; cyc = 0; hold = 0; pstall = 1'b0;
        pd = '0; pi = '0; pl = 1'b0;
        while (beats < 64 && beats < abort_at && cyc < 2000) begin
            if (mode == 0) out_ready = 1'b1;
            else if (out_valid && out_idx == 6'd3 && hold < 3) begin
                out_ready = 1'b0;
                hold++;
            end else out_ready = (cyc % 2 == 0);
            #1;
            if (pstall) begin
                check({name, " stall_valid"}, 32'(out_valid), 32'd1);
                check({name, " stall_data"}, {pl, pi, pd}, {pl, out_idx, out_data} & 32'h0 | {out_last, out_idx, out_data});
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s data[%0d]", name, beats), 32'(out_data), 32'(exp_q[beats]));
                check($sformatf("%s idx[%0d]", name, beats), 32'(out_idx), 32'(beats));
                check($sformatf("%s last[%0d]", name, beats), 32'(out_last), 32'(beats == 63));
                beats++;
            end
            pstall = out_valid && !out_ready;
            pd = out_data; pi = out_idx; pl = out_last;
            @(posedge clk); #1; cyc++;
        end
        check({name, " beat_count"}, 32'(beats), 32'((abort_at < 64) ? abort_at : 64));
        if (abort_at >= 64) begin
            check({name, " err"}, 32'(err), 32'(exp_err));
            check({name, " in_ready_after"}, 32'(in_ready), 32'd1);
            check({name, " valid_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic setup_test2();
        blk = '0;
        put_sym(0, {6'd0, 8'h05});
        put_sym(1, {6'd2, 8'hFD});
        put_sym(2, 14'h3FFF);
        clear_exp();
        exp_q[0] = 8'h05;
        exp_q[3] = 8'hFD;
    endtask

    task automatic setup_test3();
        blk = '0;
        clear_exp();
        for (int k = 0; k < 64; k++) begin
            put_sym(k, {6'd0, 8'(k + 1)});
            exp_q[k] = 8'(k + 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        blk       = '0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst err", 32'(err), 32'd0);
        check("rst out", {out_last, out_idx, out_data}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: EOB at slot 0 -> all zeros
        blk = '0;
        put_sym(0, 14'h3FFF);
        clear_exp();
        run_block("t1_zero", 0, 1'b0, 64);

        // 2: sparse block with run
        setup_test2();
        run_block("t2_sparse", 0, 1'b0, 64);

        // 3: dense 64-level block, no EOB
        setup_test3();
        run_block("t3_dense", 0, 1'b0, 64);

        // 4: run overflow drops the second level
        blk = '0;
        put_sym(0, {6'd62, 8'h11});
        put_sym(1, {6'd5, 8'h22});
        clear_exp();
        exp_q[62] = 8'h11;
        run_block("t4_ovf", 0, 1'b1, 64);

        // 5: test 2 under backpressure
        setup_test2();
        run_block("t5_bp", 1, 1'b0, 64);

        // 6: reset mid-block, then a clean block
        setup_test3();
        run_block("t6_abort", 0, 1'b0, 20);
        rst = 1'b1;
        #1;
        check("t6 rst out_valid", 32'(out_valid), 32'd0);
        check("t6 rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        setup_test2();
        run_block("t6_after", 0, 1'b0, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
